// File: rtl/uart_pkg.sv
// Shared types and constants for the UART console receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_tb_rx.sv
// UART receiver (8 data bits, LSB first, optional even parity, 1 stop) with an
// optional simulation-only line printer for captured console text.
module uart_tb_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int PARITY_EN = 0,
  parameter int PRINT_EN  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  input  logic           rx_en,
  output logic [7:0]     data_o,
  output logic           word_done,
  output logic           parity_err,
  output logic           frame_err,
  output uart_rx_state_e o_dbg_state
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  logic           w_rx_s;
  logic           r_rx_q;
  uart_rx_state_e r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_par_err;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // Output contract: word_done is a single-cycle strobe with no back-pressure;
  // data_o, parity_err and frame_err change only in that cycle and then hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_q     <= 1'b1;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      data_o     <= '0;
      word_done  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_done <= 1'b0;
      r_rx_q    <= w_rx_s;
      case (r_state)
        IDLE: begin
          // Requiring the previous sample high keeps a held-low break from re-arming.
          if (rx_en && r_rx_q && !w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == IDX_LAST) begin
              r_state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_par_err <= w_rx_s ^ (^r_shift);
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt      <= '0;
            data_o     <= r_shift;
            parity_err <= (PARITY_EN != 0) ? r_par_err : 1'b0;
            frame_err  <= ~w_rx_s;
            word_done  <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_dbg_state = r_state;

`ifndef SYNTHESIS
  if (PRINT_EN != 0) begin : g_print
    logic [7:0] r_buf [256];
    logic [7:0] r_len;

    function automatic string buf_text(input logic [7:0] n);
      string s;
      s = "";
      for (int i = 0; i < int'(n); i++) s = $sformatf("%s%c", s, r_buf[i]);
      return s;
    endfunction

    // Carriage returns are dropped so CRLF consoles print cleanly.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_len <= '0;
      end else if (word_done && data_o != 8'h0D) begin
        if (data_o == 8'h0A) begin
          $display("RX string: %s", buf_text(r_len));
          r_len <= '0;
        end else if (r_len == 8'hFF) begin
          $display("RX string: %s%c", buf_text(r_len), data_o);
          r_len <= '0;
        end else begin
          r_buf[r_len] <= data_o;
          r_len        <= r_len + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tb_rx.sv
// Directed bench for uart_tb_rx: one DUT without parity (with printer), one with parity.
module tb_uart_tb_rx;
  import uart_pkg::*;

  localparam int DIV     = 16;
  localparam int EXP_LAT = 154;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx0   = 1'b1;
  logic rx1   = 1'b1;
  logic rx_en = 1'b1;

  logic [7:0]     d0, d1;
  logic           wd0, wd1, pe0, pe1, fe0, fe1;
  uart_rx_state_e st0, st1;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int fall_cyc   = 0;
  int done_cyc   = -1;

  // Scoreboard entries are {frame_err, parity_err, data}.
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic [9:0] got0, got1, exp0, exp1;

  uart_tb_rx #(.CLK_FREQ(50_000_000), .BAUD_RATE(3_125_000), .PARITY_EN(0), .PRINT_EN(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_en(rx_en), .data_o(d0), .word_done(wd0),
    .parity_err(pe0), .frame_err(fe0), .o_dbg_state(st0)
  );

  uart_tb_rx #(.CLK_FREQ(50_000_000), .BAUD_RATE(3_125_000), .PARITY_EN(1), .PRINT_EN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_en(rx_en), .data_o(d1), .word_done(wd1),
    .parity_err(pe1), .frame_err(fe1), .o_dbg_state(st1)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: pop and compare on every strobe, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && wd0) begin
      got0     = {fe0, pe0, d0};
      done_cyc = cyc;
      compared++;
      if (exp_q0.size() == 0) begin
        assert (exp_q0.size() != 0)
          else begin mismatched++; $error("FAIL dut0_unexpected_strobe got=%h expected=none", got0); end
      end else begin
        exp0 = exp_q0.pop_front();
        assert (got0 === exp0)
          else begin mismatched++; $error("FAIL dut0_word got=%h expected=%h", got0, exp0); end
      end
    end
    if (rst_n && wd1) begin
      got1 = {fe1, pe1, d1};
      compared++;
      if (exp_q1.size() == 0) begin
        assert (exp_q1.size() != 0)
          else begin mismatched++; $error("FAIL dut1_unexpected_strobe got=%h expected=none", got1); end
      end else begin
        exp1 = exp_q1.pop_front();
        assert (got1 === exp1)
          else begin mismatched++; $error("FAIL dut1_word got=%h expected=%h", got1, exp1); end
      end
    end
  end

  // Driver tasks
  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx1 = v;
    else     rx0 = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] data, input logic stop_bit,
                      input bit has_par, input logic par_bit, input int drop_at);
    @(negedge clk);
    set_rx(sel, 1'b0);
    fall_cyc = cyc;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_at) rx_en = 1'b0;
      set_rx(sel, data[i]);
      repeat (DIV) @(negedge clk);
    end
    if (has_par) begin
      set_rx(sel, par_bit);
      repeat (DIV) @(negedge clk);
    end
    set_rx(sel, stop_bit);
    repeat (DIV) @(negedge clk);
    set_rx(sel, 1'b1);
    repeat (4 * DIV) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    compared++;
    assert ({d0, wd0, pe0, fe0} === 11'h000)
      else begin mismatched++; $error("FAIL %s_outputs got=%h expected=000", tag, {d0, wd0, pe0, fe0}); end
    compared++;
    assert (st0 === IDLE)
      else begin mismatched++; $error("FAIL %s_state got=%0d expected=%0d", tag, st0, IDLE); end
  endtask

  // Bound on the whole run
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

  // Directed sequence
  initial begin
    repeat (5) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Valid 0x41 and its strobe latency, counted from the first edge that sees the low line
    exp_q0.push_back({1'b0, 1'b0, 8'h41});
    send(1'b0, 8'h41, 1'b1, 1'b0, 1'b0, -1);
    compared++;
    assert (done_cyc - fall_cyc - 1 === EXP_LAT)
      else begin mismatched++; $error("FAIL latency got=%0d expected=%0d", done_cyc - fall_cyc - 1, EXP_LAT); end

    // Short glitch: start detected, rejected at mid start bit
    @(negedge clk);
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    assert (st0 === START)
      else begin mismatched++; $error("FAIL glitch_start got=%0d expected=%0d", st0, START); end
    rx0 = 1'b1;
    repeat (30) @(negedge clk);
    compared++;
    assert (st0 === IDLE)
      else begin mismatched++; $error("FAIL glitch_idle got=%0d expected=%0d", st0, IDLE); end

    // Bad stop bit, then a good frame clears frame_err
    exp_q0.push_back({1'b1, 1'b0, 8'h55});
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
    exp_q0.push_back({1'b0, 1'b0, 8'h0A});
    send(1'b0, 8'h0A, 1'b1, 1'b0, 1'b0, -1);

    // Break: one strobe with 0x00 and frame_err, no re-trigger while held low
    exp_q0.push_back({1'b1, 1'b0, 8'h00});
    @(negedge clk);
    rx0 = 1'b0;
    repeat (12 * DIV) @(negedge clk);
    rx0 = 1'b1;
    repeat (4 * DIV) @(negedge clk);

    // Disabled receiver ignores a frame; dropping rx_en mid-frame still completes it
    rx_en = 1'b0;
    send(1'b0, 8'h31, 1'b1, 1'b0, 1'b0, -1);
    rx_en = 1'b1;
    exp_q0.push_back({1'b0, 1'b0, 8'h62});
    send(1'b0, 8'h62, 1'b1, 1'b0, 1'b0, 3);
    rx_en = 1'b1;

    // Reset during bit 4 of a frame discards it
    @(negedge clk);
    rx0 = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx0 = (i == 0);
      repeat (DIV) @(negedge clk);
    end
    rst_n = 1'b0;
    rx0   = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);

    // "Hi\n" through the printer
    exp_q0.push_back({1'b0, 1'b0, 8'h48});
    send(1'b0, 8'h48, 1'b1, 1'b0, 1'b0, -1);
    exp_q0.push_back({1'b0, 1'b0, 8'h69});
    send(1'b0, 8'h69, 1'b1, 1'b0, 1'b0, -1);
    exp_q0.push_back({1'b0, 1'b0, 8'h0A});
    send(1'b0, 8'h0A, 1'b1, 1'b0, 1'b0, -1);

    // Even parity on the parity-enabled receiver: 0x03 has two ones
    exp_q1.push_back({1'b0, 1'b0, 8'h03});
    send(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, -1);
    exp_q1.push_back({1'b0, 1'b1, 8'h03});
    send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, -1);
    exp_q1.push_back({1'b1, 1'b0, 8'hC5});
    send(1'b1, 8'hC5, 1'b0, 1'b1, 1'b0, -1);

    // Every expected word must have been seen
    repeat (4 * DIV) @(negedge clk);
    compared++;
    assert (exp_q0.size() === 0)
      else begin mismatched++; $error("FAIL dut0_missing_words got=%0d expected=0", exp_q0.size()); end
    compared++;
    assert (exp_q1.size() === 0)
      else begin mismatched++; $error("FAIL dut1_missing_words got=%0d expected=0", exp_q1.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
